// File: rtl/multdiv_ctrl_pkg.sv
// Shared constants and types for the multdiv sequencing controller.
package multdiv_ctrl_pkg;

   localparam logic [4:0] OP_ALU      = 5'b00000;
   localparam logic [4:0] ALU_MUL     = 5'b00110;
   localparam logic [4:0] ALU_DIV     = 5'b00111;
   localparam logic [4:0] REG_RSTATUS = 5'd30;

   localparam logic [31:0] RSTATUS_MUL = 32'd4;
   localparam logic [31:0] RSTATUS_DIV = 32'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [4:0] opcode;
      logic [4:0] rd;
      logic [4:0] alu_op;
   } inst_fields_t;

endpackage

// File: rtl/multdiv_ctrl_md_watchdog.sv
// BUSY-cycle counter; expired flags the last cycle allowed before forcing completion.
module md_watchdog #(
   parameter int MAX_CYCLES = 40,
   parameter int CNT_W      = 6
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = enable && (count == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Issues mul/div start pulses, stalls the front end while the unit works,
// and presents a single-cycle writeback (redirected to rstatus on exception).
module multdiv_ctrl
   import multdiv_ctrl_pkg::*;
#(
   parameter int MAX_CYCLES = 40,
   parameter int CNT_W      = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] x_inst,
   input  logic        x_valid,
   input  logic        flush,
   input  logic        md_ready,
   input  logic        md_exception,
   output logic        ctrl_mult,
   output logic        ctrl_div,
   output logic        stall,
   output logic        busy,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic        wb_use_status,
   output logic [31:0] wb_status,
   output logic        timeout
);

   inst_fields_t f;
   logic         unused_bits;
   logic         is_mul;
   logic         is_div;
   logic         start;
   logic         expired;

   state_t     state;
   state_t     state_n;
   logic [4:0] rd_q;
   logic       div_q;
   logic       exc_q;
   logic       timeout_q;

   assign f = '{opcode: x_inst[31:27],
                rd:     x_inst[26:22],
                alu_op: x_inst[6:2]};
   assign unused_bits = ^{x_inst[21:7], x_inst[1:0]};

   assign is_mul = (f.opcode == OP_ALU) && (f.alu_op == ALU_MUL);
   assign is_div = (f.opcode == OP_ALU) && (f.alu_op == ALU_DIV);
   assign start  = (state == IDLE) && x_valid && (is_mul || is_div) && !flush;

   md_watchdog #(
      .MAX_CYCLES (MAX_CYCLES),
      .CNT_W      (CNT_W)
   ) u_wd (
      .clock   (clock),
      .reset   (reset),
      .clear   (start),
      .enable  (state == BUSY),
      .expired (expired)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (start) state_n = BUSY;
         BUSY: begin
            if (flush) begin
               state_n = IDLE;
            end else if (md_ready || expired) begin
               state_n = DONE;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // md_ready takes priority over the watchdog on the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_q      <= '0;
         div_q     <= 1'b0;
         exc_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else if (start) begin
         rd_q  <= f.rd;
         div_q <= is_div;
         exc_q <= 1'b0;
      end else if (state == BUSY && !flush) begin
         if (md_ready) begin
            exc_q <= md_exception;
         end else if (expired) begin
            exc_q     <= 1'b1;
            timeout_q <= 1'b1;
         end
      end
   end

   always_comb begin
      ctrl_mult     = 1'b0;
      ctrl_div      = 1'b0;
      stall         = 1'b0;
      busy          = 1'b0;
      wb_valid      = 1'b0;
      wb_rd         = '0;
      wb_use_status = 1'b0;
      wb_status     = '0;
      unique case (state)
         IDLE: begin
            ctrl_mult = start && is_mul;
            ctrl_div  = start && is_div;
            stall     = start;
         end
         BUSY: begin
            stall = 1'b1;
            busy  = 1'b1;
         end
         DONE: begin
            busy     = 1'b1;
            wb_valid = !flush;
            if (!flush) begin
               wb_use_status = exc_q;
               wb_rd         = exc_q ? REG_RSTATUS : rd_q;
               if (exc_q) begin
                  wb_status = div_q ? RSTATUS_DIV : RSTATUS_MUL;
               end
            end
         end
         default: ;
      endcase
      if (reset) begin
         ctrl_mult     = 1'b0;
         ctrl_div      = 1'b0;
         stall         = 1'b0;
         busy          = 1'b0;
         wb_valid      = 1'b0;
         wb_rd         = '0;
         wb_use_status = 1'b0;
         wb_status     = '0;
      end
   end

   assign timeout = timeout_q && !reset;

endmodule
